// File: rtl/word_ser_pkg.sv
// Shared types and helpers for the word-to-byte serializer.
package word_ser_pkg;

   typedef enum logic [1:0] {
      IDLE,
      EMIT,
      WAIT_ACK
   } state_t;

   // Ceiling log2, usable in parameter expressions.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

   // A zero or oversized byte count means "send the whole word".
   function automatic int clamp_nbytes(input int nbytes, input int nb);
      return (nbytes == 0 || nbytes > nb) ? nb : nbytes;
   endfunction

endpackage

// File: rtl/word_serializer_v3_shift.sv
// Load/shift register presenting its head byte for both byte orders.
module ser_shift_reg #(
   parameter int WORD_W = 32,
   parameter int BYTE_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [WORD_W-1:0] load_data,
   input  logic              shift,
   input  logic              msb_first,
   output logic [BYTE_W-1:0] head_lsb,
   output logic [BYTE_W-1:0] head_msb
);

   logic [WORD_W-1:0] word_q;

   // Load a new word, or move the next byte to the head end, zero-filling behind it.
   always_ff @(posedge clk) begin
      if (reset) begin
         word_q <= '0;
      end else if (load) begin
         word_q <= load_data;
      end else if (shift) begin
         word_q <= msb_first ? (word_q << BYTE_W) : (word_q >> BYTE_W);
      end
   end

   assign head_lsb = word_q[BYTE_W-1:0];
   assign head_msb = word_q[WORD_W-1 -: BYTE_W];

endmodule

// File: rtl/word_serializer_v3.sv
// Word-to-byte serializer feeding the UART transmitter: one-word holding
// buffer, shifter, and an IDLE/EMIT/WAIT_ACK sequencer paced by tx_done.
module word_serializer_v3
   import word_ser_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int BYTE_W = 8,
   localparam int NB    = WORD_W / BYTE_W,
   localparam int CNT_W = clog2(NB + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WORD_W-1:0] in_data,
   input  logic [CNT_W-1:0]  in_nbytes,
   input  logic              in_msb_first,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [BYTE_W-1:0] byte_out,
   output logic              byte_stb,
   input  logic              tx_done,
   output logic              last_byte,
   output logic              busy
);

   state_t            state;
   state_t            state_nxt;
   logic              hold_valid;
   logic [WORD_W-1:0] hold_data;
   logic [CNT_W-1:0]  hold_nbytes;
   logic              hold_msb;
   logic [CNT_W-1:0]  remaining;
   logic              cur_msb;
   logic [BYTE_W-1:0] byte_q;
   logic              load;
   logic              shift;
   logic              accept;
   logic [BYTE_W-1:0] head_lsb;
   logic [BYTE_W-1:0] head_msb;
   logic [BYTE_W-1:0] head;

   // Buffer space is judged from registered state only, so a word leaving
   // hold cannot be replaced in the same cycle.
   assign in_ready = !hold_valid && !reset;
   assign accept   = in_valid && in_ready;

   // Holding-buffer occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         hold_valid <= 1'b0;
      end else if (accept) begin
         hold_valid <= 1'b1;
      end else if (load) begin
         hold_valid <= 1'b0;
      end
   end

   // Holding-buffer payload; byte order and clamped count are frozen here.
   always_ff @(posedge clk) begin
      if (accept) begin
         hold_data   <= in_data;
         hold_nbytes <= CNT_W'(clamp_nbytes(int'(in_nbytes), NB));
         hold_msb    <= in_msb_first;
      end
   end

   // Sequencer state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state plus shifter load/shift controls.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      shift     = 1'b0;
      case (state)
         IDLE: begin
            if (hold_valid) begin
               load      = 1'b1;
               state_nxt = EMIT;
            end
         end
         EMIT: begin
            shift     = 1'b1;
            state_nxt = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (tx_done) begin
               if (remaining != '0) begin
                  state_nxt = EMIT;
               end else if (hold_valid) begin
                  // Back-to-back: next word goes straight into the shifter.
                  load      = 1'b1;
                  state_nxt = EMIT;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Per-word byte count and byte order of the word in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         remaining <= '0;
         cur_msb   <= 1'b0;
      end else if (load) begin
         remaining <= hold_nbytes;
         cur_msb   <= hold_msb;
      end else if (shift) begin
         remaining <= remaining - CNT_W'(1);
      end
   end

   // Keep the emitted byte on byte_out until the next strobe.
   always_ff @(posedge clk) begin
      if (reset) begin
         byte_q <= '0;
      end else if (shift) begin
         byte_q <= head;
      end
   end

   ser_shift_reg #(
      .WORD_W(WORD_W),
      .BYTE_W(BYTE_W)
   ) u_shift (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .load_data(hold_data),
      .shift    (shift),
      .msb_first(cur_msb),
      .head_lsb (head_lsb),
      .head_msb (head_msb)
   );

   assign head      = cur_msb ? head_msb : head_lsb;
   assign byte_stb  = (state == EMIT);
   assign byte_out  = byte_stb ? head : byte_q;
   assign last_byte = byte_stb && (remaining == CNT_W'(1));
   assign busy      = (state != IDLE);

endmodule
